// File: rtl/pixel_fb_writer_pkg.sv
// Shared graphics definitions for the pixel frame-buffer writer:
// float32 field layout, FIFO entry format and RGB565 packing.
package pixel_fb_writer_pkg;

    localparam int unsigned FLOAT_W   = 32;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MANT_W    = 23;
    localparam int unsigned EXP_BIAS  = 127;

    // Address width carried inside a FIFO entry; sized for the default frame.
    localparam int unsigned FB_ADDR_W = 20;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [15:0]          data;
        logic                 is_last;
    } fb_entry_t;

    function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/pixel_fb_writer_float_to_u8.sv
// Combinational float32 -> saturated unsigned 8-bit conversion (truncating).
module float_to_u8
    import pixel_fb_writer_pkg::*;
(
    input  logic [FLOAT_W-1:0] f_in,
    output logic [7:0]         u8_out
);

    logic              sign;
    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W:0]   mant;
    logic [4:0]        shamt;

    // Classify the operand, then shift the implicit-one mantissa for 1.0..255.x
    always_comb begin
        sign   = f_in[FLOAT_W-1];
        exp_f  = f_in[FLOAT_W-2 -: EXP_W];
        mant   = {1'b1, f_in[MANT_W-1:0]};
        // Only meaningful for exponents 127..134, giving shifts of 23..16
        shamt  = 5'(8'(EXP_BIAS + MANT_W) - exp_f);
        u8_out = '0;
        if (sign) begin
            u8_out = '0;
        end else if (exp_f == '1) begin
            u8_out = '1;
        end else if (exp_f < 8'(EXP_BIAS)) begin
            u8_out = '0;
        end else if (exp_f >= 8'(EXP_BIAS + 8)) begin
            u8_out = '1;
        end else begin
            u8_out = 8'(mant >> shamt);
        end
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// Pixel colour consumer: converts float RGB to RGB565, computes the
// frame-buffer address, queues entries and drains them to a BRAM write port.
module pixel_fb_writer
    import pixel_fb_writer_pkg::*;
#(
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 720,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = FB_ADDR_W
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [31:0]              r_in,
    input  logic [31:0]              g_in,
    input  logic [31:0]              b_in,
    input  logic [10:0]              x_in,
    input  logic [9:0]               y_in,
    input  logic                     rgb_valid_in,
    input  logic                     fb_ready_in,
    output logic [ADDR_W-1:0]        fb_addr_out,
    output logic [15:0]              fb_data_out,
    output logic                     fb_we_out,
    output logic                     frame_done_out,
    output logic                     overflow_out,
    output logic [$clog2(DEPTH):0]   fifo_count_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]           r_u8, g_u8, b_u8;
    logic                 in_range;
    fb_entry_t            s1_next;
    logic                 s1_valid;
    fb_entry_t            s1_entry;

    fb_entry_t            mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;
    fb_entry_t            head;

    float_to_u8 u_f2u_r (.f_in(r_in), .u8_out(r_u8));
    float_to_u8 u_f2u_g (.f_in(g_in), .u8_out(g_u8));
    float_to_u8 u_f2u_b (.f_in(b_in), .u8_out(b_u8));

    // Stage-1 combinational payload: range check, address, colour, frame end
    always_comb begin
        in_range        = (32'(x_in) < WIDTH) && (32'(y_in) < HEIGHT);
        s1_next.addr    = FB_ADDR_W'(y_in) * FB_ADDR_W'(WIDTH) + FB_ADDR_W'(x_in);
        s1_next.data    = pack_rgb565(r_u8, g_u8, b_u8);
        s1_next.is_last = (32'(x_in) == WIDTH - 1) && (32'(y_in) == HEIGHT - 1);
    end

    // Stage-1 register; out-of-frame samples never become valid
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else begin
            s1_valid <= rgb_valid_in && in_range;
            if (rgb_valid_in) begin
                s1_entry <= s1_next;
            end
        end
    end

    // FIFO handshake: a pop in the same cycle frees the slot for a push at full
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(DEPTH));
        pop        = !fifo_empty && fb_ready_in;
        push       = s1_valid && (!fifo_full || pop);
        head       = mem[rd_ptr];
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= s1_entry;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (s1_valid && !push) begin
                overflow_out <= 1'b1;
            end
        end
    end

    // Registered write port; address/data hold between strobes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fb_we_out      <= 1'b0;
            frame_done_out <= 1'b0;
            fb_addr_out    <= '0;
            fb_data_out    <= '0;
        end else begin
            fb_we_out      <= pop;
            frame_done_out <= pop && head.is_last;
            if (pop) begin
                fb_addr_out <= ADDR_W'(head.addr);
                fb_data_out <= head.data;
            end
        end
    end

    assign fifo_count_out = count;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer: conversion vector table,
// hand-written backpressure/overflow/reset/frame-end sequences and a
// randomized run against a queue-based reference model.
module tb_pixel_fb_writer;

    localparam int W  = 1280;
    localparam int H  = 720;
    localparam int D  = 16;
    localparam int AW = 20;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [31:0]       r_in, g_in, b_in;
    logic [10:0]       x_in;
    logic [9:0]        y_in;
    logic              rgb_valid_in;
    logic              fb_ready_in;
    logic [AW-1:0]     fb_addr_out;
    logic [15:0]       fb_data_out;
    logic              fb_we_out;
    logic              frame_done_out;
    logic              overflow_out;
    logic [4:0]        fifo_count_out;

    always #5 clk_in = ~clk_in;

    pixel_fb_writer #(
        .WIDTH (W),
        .HEIGHT(H),
        .DEPTH (D),
        .ADDR_W(AW)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .r_in          (r_in),
        .g_in          (g_in),
        .b_in          (b_in),
        .x_in          (x_in),
        .y_in          (y_in),
        .rgb_valid_in  (rgb_valid_in),
        .fb_ready_in   (fb_ready_in),
        .fb_addr_out   (fb_addr_out),
        .fb_data_out   (fb_data_out),
        .fb_we_out     (fb_we_out),
        .frame_done_out(frame_done_out),
        .overflow_out  (overflow_out),
        .fifo_count_out(fifo_count_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int addr;
        int data;
        bit last;
    } ent_t;

    ent_t m_q[$];
    bit   m_pv;
    ent_t m_pe;
    bit   m_we, m_done, m_ovf;
    int   m_addr, m_data;

    // Value-based conversion: decode the float to a real and clamp/truncate it
    function automatic int ref_u8(input logic [31:0] f);
        int  e;
        int  man;
        real v;
        e   = int'(f[30:23]);
        man = int'(f[22:0]);
        if (f[31]) return 0;
        if (e == 255) return 255;
        if (e == 0) return 0;
        v = (1.0 + real'(man) / 8388608.0) * (2.0 ** real'(e - 127));
        if (v >= 256.0) return 255;
        if (v < 1.0) return 0;
        return $rtoi(v);
    endfunction

    function automatic ent_t make_ent(input logic [31:0] r, input logic [31:0] g,
                                      input logic [31:0] b, input int x, input int y);
        ent_t e;
        e.data = ((ref_u8(r) / 8) * 2048) + ((ref_u8(g) / 4) * 32) + (ref_u8(b) / 8);
        e.addr = y * W + x;
        e.last = (x == W - 1) && (y == H - 1);
        return e;
    endfunction

    task automatic model_edge();
        bit   pop;
        ent_t h;
        if (rst_in) begin
            m_q.delete();
            m_pv = 0; m_we = 0; m_done = 0; m_ovf = 0; m_addr = 0; m_data = 0;
        end else begin
            pop = (m_q.size() > 0) && fb_ready_in;
            if (pop) begin
                h = m_q.pop_front();
                m_we = 1; m_done = h.last; m_addr = h.addr; m_data = h.data;
            end else begin
                m_we = 0; m_done = 0;
            end
            if (m_pv) begin
                if (m_q.size() < D) m_q.push_back(m_pe);
                else m_ovf = 1;
            end
            m_pv = rgb_valid_in && (int'(x_in) < W) && (int'(y_in) < H);
            if (m_pv) m_pe = make_ent(r_in, g_in, b_in, int'(x_in), int'(y_in));
        end
    endtask

    // One clock: model follows the edge, then all outputs are compared
    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        chk("fifo_count", 32'(fifo_count_out), 32'(m_q.size()));
        chk("overflow", 32'(overflow_out), 32'(m_ovf));
        chk("fb_we", 32'(fb_we_out), 32'(m_we));
        chk("frame_done", 32'(frame_done_out), 32'(m_done));
        chk("fb_addr", 32'(fb_addr_out), 32'(m_addr));
        chk("fb_data", 32'(fb_data_out), 32'(m_data));
    endtask

    task automatic drive(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                         input int x, input int y);
        r_in = r; g_in = g; b_in = b;
        x_in = 11'(x); y_in = 10'(y);
        rgb_valid_in = 1'b1;
    endtask

    task automatic idle();
        rgb_valid_in = 1'b0;
        r_in = $urandom; g_in = $urandom; b_in = $urandom;
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] bits;
        bits = $urandom;
        if ($urandom_range(0, 3) == 0) return bits;
        return {($urandom_range(0, 7) == 0), 8'($urandom_range(124, 137)), bits[22:0]};
    endfunction

    // ---------------- conversion vector table ----------------
    typedef struct {
        logic [31:0] r, g, b;
        int          x, y;
        int          exp_data;
        int          exp_addr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int nwr;

        tbl[0] = '{32'h437F0000, 32'h43000000, 32'h00000000,   10,   2, 16'hFC00,   2570};
        tbl[1] = '{32'h447A0000, 32'hC0A00000, 32'h3F000000,    0,   0, 16'hF800,      0};
        tbl[2] = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1279,   0, 16'hFFFF,   1279};
        tbl[3] = '{32'hFFC00000, 32'hFFC00000, 32'hFFC00000,    0,   1, 16'h0000,   1280};
        tbl[4] = '{32'h7F800000, 32'h7F800000, 32'h7F800000,    5, 100, 16'hFFFF, 128005};
        tbl[5] = '{32'h80000000, 32'h80000000, 32'h80000000,  640, 360, 16'h0000, 461440};
        tbl[6] = '{32'h43800000, 32'h42FE0000, 32'h40E00000,    1,   1, 16'hFBE0,   1281};
        tbl[7] = '{32'h41000000, 32'h40800000, 32'h41880000,  100, 719, 16'h0822, 920420};
        tbl[8] = '{32'h00000001, 32'h3F7FFFFF, 32'h3F800000,    7,   3, 16'h0000,   3847};

        rst_in = 1'b1; fb_ready_in = 1'b0;
        x_in = '0; y_in = '0;
        idle();
        tick(); tick();
        chk("reset_count", 32'(fifo_count_out), 32'd0);
        chk("reset_we", 32'(fb_we_out), 32'd0);
        rst_in = 1'b0;

        // Single-pixel latency and conversion: strobe appears three edges later
        fb_ready_in = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].x, tbl[i].y);
            tick();
            idle();
            tick();
            chk("tbl_we_early", 32'(fb_we_out), 32'd0);
            tick();
            chk("tbl_we", 32'(fb_we_out), 32'd1);
            chk("tbl_data", 32'(fb_data_out), 32'(tbl[i].exp_data));
            chk("tbl_addr", 32'(fb_addr_out), 32'(tbl[i].exp_addr));
            tick();
        end

        // Backpressure: 17 samples into a 16-entry FIFO, then drain in order
        fb_ready_in = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(rand_float(), rand_float(), rand_float(), i, 5);
            tick();
        end
        idle();
        tick();
        chk("ovf_count_full", 32'(fifo_count_out), 32'd16);
        chk("ovf_flag", 32'(overflow_out), 32'd1);
        fb_ready_in = 1'b1;
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fb_we_out) begin
                chk("ovf_order_addr", 32'(fb_addr_out), 32'(5 * W + nwr));
                nwr++;
            end
        end
        chk("ovf_write_count", 32'(nwr), 32'd16);

        // Reset with entries queued clears FIFO, strobe and sticky overflow
        fb_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(rand_float(), rand_float(), rand_float(), i, 9);
            tick();
        end
        idle();
        tick(); tick();
        chk("rst_pre_count", 32'(fifo_count_out), 32'd5);
        rst_in = 1'b1;
        tick();
        chk("rst_count", 32'(fifo_count_out), 32'd0);
        chk("rst_we", 32'(fb_we_out), 32'd0);
        chk("rst_ovf", 32'(overflow_out), 32'd0);
        rst_in = 1'b0; fb_ready_in = 1'b1;
        tick();
        chk("post_rst_we", 32'(fb_we_out), 32'd0);
        tick();

        // Full FIFO with a continuous stream and ready high: occupancy steady
        fb_ready_in = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(rand_float(), rand_float(), rand_float(), i, 20);
            tick();
        end
        chk("pp_count_full", 32'(fifo_count_out), 32'd16);
        fb_ready_in = 1'b1;
        for (int i = 17; i < 37; i++) begin
            drive(rand_float(), rand_float(), rand_float(), i, 20);
            tick();
            chk("pp_count", 32'(fifo_count_out), 32'd16);
            chk("pp_we", 32'(fb_we_out), 32'd1);
            chk("pp_ovf", 32'(overflow_out), 32'd0);
        end
        idle();
        for (int i = 0; i < 20; i++) tick();

        // Last pixel of the frame, then out-of-range pixels
        drive(32'h437F0000, 32'h437F0000, 32'h437F0000, W - 1, H - 1);
        tick();
        idle();
        tick(); tick();
        chk("fe_we", 32'(fb_we_out), 32'd1);
        chk("fe_done", 32'(frame_done_out), 32'd1);
        chk("fe_addr", 32'(fb_addr_out), 32'd921599);
        tick();
        chk("fe_done_clear", 32'(frame_done_out), 32'd0);
        drive(32'h437F0000, 32'h437F0000, 32'h437F0000, W, 0);
        tick();
        drive(32'h437F0000, 32'h437F0000, 32'h437F0000, 0, H);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("oor_we", 32'(fb_we_out), 32'd0);
            chk("oor_count", 32'(fifo_count_out), 32'd0);
        end

        // Randomized traffic with occasional out-of-range coordinates and resets
        for (int i = 0; i < 4000; i++) begin
            rst_in = ($urandom_range(0, 699) == 0);
            fb_ready_in = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                               : ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 8) begin
                drive(rand_float(), rand_float(), rand_float(),
                      int'($urandom_range(0, 1300)), int'($urandom_range(0, 730)));
            end else begin
                idle();
            end
            tick();
        end
        rst_in = 1'b0;
        idle();
        fb_ready_in = 1'b1;
        for (int i = 0; i < 24; i++) tick();
        chk("final_drain_count", 32'(fifo_count_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
Consumer end of the pixel colour interface: accepts float32 r/g/b samples with `rgb_valid` (no backpressure on the upstream side) plus delay-matched pixel coordinates.
Converts each channel to a saturated 8-bit integer, packs RGB565 and computes the frame-buffer address.
Buffers entries in a FIFO and drains them to a BRAM write port that has a ready signal.
Sits between `get_pixel_color` and the frame buffer.

Parameters:
WIDTH, 1280, horizontal pixels per frame
HEIGHT, 720, vertical pixels per frame
DEPTH, 16, FIFO entries (power of two, ≥4)
ADDR_W, 20, frame-buffer address width; WIDTH*HEIGHT must fit

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
r_in  input  32  red channel, IEEE-754 single, nominal 0.0–255.0
g_in  input  32  green channel, same format
b_in  input  32  blue channel, same format
x_in  input  11  pixel column, delay-matched to rgb_valid_in
y_in  input  10  pixel row, delay-matched to rgb_valid_in
rgb_valid_in  input  1  sample valid; one-cycle qualifier, no ready
fb_ready_in  input  1  frame buffer accepts a write this cycle
fb_addr_out  output  ADDR_W  write address = y*WIDTH + x
fb_data_out  output  16  RGB565 = {r[7:3], g[7:2], b[7:3]}
fb_we_out  output  1  write strobe, single-cycle per pixel
frame_done_out  output  1  one-cycle pulse when pixel (WIDTH-1, HEIGHT-1) is written
overflow_out  output  1  sticky; set when a valid sample is dropped because the FIFO is full
fifo_count_out  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset:
  - all outputs 0; FIFO empty; stage-1 valid cleared; overflow cleared.
  - Reset mid-operation discards stage-1 and all FIFO contents; no write is issued in the cycle after reset deasserts.
- Stage 1 (registered, cycle N → N+1), on rgb_valid_in:
  - convert each channel with float_to_u8;
  - compute address and RGB565;
  - if x_in ≥ WIDTH or y_in ≥ HEIGHT, the sample is silently dropped (stage-1 valid = 0).
- float_to_u8 rules, with e = exponent field and m = {1, mantissa}:
  - sign = 1 (including -0) → 0
  - e = 255 (Inf or NaN) → 255 if sign = 0
  - e < 127 (value < 1.0, including denormals and zero) → 0
  - e ≥ 135 (value ≥ 256) → 255
  - else → m >> (150 − e), truncated (no rounding)
- Stage 2 (FIFO push):
  - stage-1 valid pushes {addr, data, is_last} at the end of cycle N+1;
  - is_last = (x == WIDTH-1 && y == HEIGHT-1).
- Drain (registered output):
  - each edge, if FIFO is non-empty and fb_ready_in = 1: pop; fb_we_out = 1 with the popped addr/data; frame_done_out = popped is_last.
  - Otherwise fb_we_out = 0 and frame_done_out = 0; addr/data hold their last value.
  - fb_ready_in is sampled in the cycle before the write strobe.
- Latency: rgb_valid_in at cycle N → fb_we_out high at cycle N+3 when the FIFO is empty and fb_ready_in = 1.
- Throughput: one pixel per cycle sustained.
- Simultaneous push and pop: allowed in the same cycle; occupancy is unchanged.
  - Push when full with a simultaneous pop: accepted (the pop frees the slot).
  - Push when full with no pop: entry dropped; overflow_out set and held until reset; no existing entry is modified.
- Pop from empty: never occurs; fb_we_out stays 0.
- Ordering: strict FIFO; output order equals input order.
- Pointers wrap modulo DEPTH; occupancy is a separate counter (0..DEPTH).

Decomposition:
- Shared package (graphics package):
  - RGB565 packing function;
  - float field widths/bias constants (EXP_BIAS=127, MANT_W=23);
  - the packed FIFO entry struct {addr, data, is_last}.
- Sub-module float_to_u8: purely combinational; three instances inside stage 1.
- The FIFO is inline: array plus read/write pointers and counter.

Test Plan:
- Single pixel: r = 0x437F0000 (255.0), g = 0x43000000 (128.0), b = 0x00000000, x = 10, y = 2, fb_ready_in = 1 → fb_we_out at N+3, fb_addr_out = 2570, fb_data_out = 0xFC00.
- Saturation and clamping: r = 0x447A0000 (1000.0), g = 0xC0A00000 (−5.0), b = 0x3F000000 (0.5) → 0xF800. Also r = g = b = 0x7FC00000 (NaN) → 0xFFFF.
- Backpressure and overflow: fb_ready_in = 0; 17 consecutive valid samples with DEPTH = 16 →
  - fifo_count_out = 16;
  - overflow_out = 1 after the 17th;
  - after fb_ready_in = 1, exactly 16 writes in input order.
- Simultaneous push/pop at full: hold count at 16, then ready = 1 with a continuous valid stream → count stays 16, no overflow, one write per cycle.
- Frame end and out-of-range: pixel (1279, 719) → frame_done_out pulses with its write, fb_addr_out = 921599. Pixel (1280, 0) → no write, count unchanged.
- Reset mid-stream: assert rst_in with 5 entries queued → next cycle fifo_count_out = 0, fb_we_out = 0, overflow_out = 0.
